// File: rtl/booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier
//   Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
//   One Booth step per clock. Each step does one add or subtract through a
//   single carryBypassAdder instance. The first step follows the accepting
//   edge, and the product appears WIDTH clocks after acceptance.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   start        in   request strobe, sampled only in IDLE or DONE
//   multiplicand in   signed operand M, captured on the accepting edge
//   multiplier   in   signed operand Q, captured on the accepting edge
//   busy         out  high while an operation is iterating
//   done         out  one-cycle pulse, product valid
//   product      out  signed product, held until the next done
//
// Also in this file: carryBypassAdder, the 32-bit adder used by the
// iteration datapath.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// carryBypassAdder
//   Combinational WIDTH-bit adder built from BLOCK-bit ripple groups. When
//   every bit of a group propagates, the group's carry-in bypasses the ripple
//   chain and goes straight to the next group.
//
// Ports
//   a, b      in   addends
//   cin       in   carry in
//   result    out  a + b + cin (WIDTH bits)
//   cout      out  carry out of the MSB
//   overflow  out  two's-complement overflow of the signed sum
// ---------------------------------------------------------------------------
module carryBypassAdder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] prop_s;
  logic [WIDTH-1:0] gen_s;

  assign prop_s = a ^ b;
  assign gen_s  = a & b;

  // Ripple inside each group; bypass the group carry when it fully propagates
  always_comb begin : bypass_chain
    logic blk_carry;
    logic rip_carry;
    logic all_prop;
    result    = '0;
    blk_carry = cin;
    rip_carry = 1'b0;
    all_prop  = 1'b0;
    for (int blk = 0; blk < NBLK; blk++) begin
      rip_carry = blk_carry;
      all_prop  = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        result[blk*BLOCK+i] = prop_s[blk*BLOCK+i] ^ rip_carry;
        rip_carry = gen_s[blk*BLOCK+i] | (prop_s[blk*BLOCK+i] & rip_carry);
        all_prop  = all_prop & prop_s[blk*BLOCK+i];
      end
      if (all_prop) begin
        blk_carry = blk_carry;
      end else begin
        blk_carry = rip_carry;
      end
    end
    cout = blk_carry;
  end

  // Signed overflow: operands share a sign and the result sign differs
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);

endmodule

module booth_seq_multiplier #(
  parameter int WIDTH = 32,   // only 32 is supported (adder width)
  parameter int CNT_W = 6     // 2**CNT_W must exceed WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     add_b_s;
  logic                 add_cin_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 sum_ovf_s;
  logic                 unused_adder_cout;
  logic                 s_msb_s;

  // Booth recoding of the bit pair {Q[0], q_m1} into adder operand and carry
  always_comb begin
    add_b_s   = '0;
    add_cin_s = 1'b0;
    case ({q_q[0], qm1_q})
      2'b01: begin
        add_b_s   = m_q;
        add_cin_s = 1'b0;
      end
      2'b10: begin
        add_b_s   = ~m_q;
        add_cin_s = 1'b1;
      end
      default: begin
        add_b_s   = '0;
        add_cin_s = 1'b0;
      end
    endcase
  end

  carryBypassAdder #(.WIDTH(WIDTH), .BLOCK(4)) u_adder (
    .a        (a_q),
    .b        (add_b_s),
    .cin      (add_cin_s),
    .result   (sum_s),
    .cout     (unused_adder_cout),
    .overflow (sum_ovf_s)
  );

  // The true sign of the (WIDTH+1)-bit sum. Without it, A - 0x80000000
  // shifts in the wrong sign bit.
  assign s_msb_s = sum_s[WIDTH-1] ^ sum_ovf_s;

  // Next-state and datapath: accept, iterate, finish
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Arithmetic right shift of {s_msb, S, Q} into {A, Q, q_m1}
        a_d     = {s_msb_s, sum_s[WIDTH-1:1]};
        q_d     = {sum_s[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (count_q == LAST_CNT) begin
          product_d = {a_d, q_d};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int tests_run;
  int tests_failed;
  int cyc;
  logic busy_ok;
  logic seen_done;

  booth_seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance edge by edge until done (sampled 1 time unit after each edge),
  // counting edges; busy must stay high on every cycle before done.
  task automatic wait_done(output int n, output logic bok);
    n   = 0;
    bok = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Start one operation with a single-cycle start, then check it completes.
  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] exp);
    int n;
    logic bok;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, bok);
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_busy_run"}, {63'd0, bok}, 64'd1);
    check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_product"}, product, exp);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = 32'd0;
    multiplier   = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, product[61:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: -3 * 5
    run_op("t1", 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFFFFFFFFF1);
    // 2: most negative squared (subtract overflow path)
    run_op("t2", 32'h80000000, 32'h80000000, 64'h4000000000000000);
    // 3: max positive squared, then min * -1
    run_op("t3a", 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001);
    run_op("t3b", 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000);

    // 4: back-to-back with start held high
    @(negedge clk);
    multiplicand = 32'h00000007;
    multiplier   = 32'h00000006;
    start        = 1'b1;
    @(posedge clk); #1;
    multiplicand = 32'h11111111;   // must be ignored while busy
    multiplier   = 32'h22222222;
    wait_done(cyc, busy_ok);
    check("t4_first_latency", 64'(cyc), 64'd32);
    check("t4_first_product", product, 64'h000000000000002A);
    multiplicand = 32'hFFFFFFFF;   // sampled on the edge leaving DONE
    multiplier   = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("t4_second_accept", {62'd0, busy, done}, 64'd2);
    check("t4_product_held", product, 64'h000000000000002A);
    multiplicand = 32'h33333333;
    multiplier   = 32'h44444444;
    wait_done(cyc, busy_ok);
    start = 1'b0;
    check("t4_second_spacing", 64'(cyc + 1), 64'd33);
    check("t4_second_product", product, 64'h0000000000000001);
    @(posedge clk); #1;
    check("t4_idle_after", {62'd0, busy, done}, 64'd0);

    // 5: asynchronous reset in the middle of an operation
    @(negedge clk);
    multiplicand = 32'h12345678;
    multiplier   = 32'h9ABCDEF0;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_clear", {busy, done, product[61:0]}, 64'd0);
    check("t5_product_clear", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    check("t5_no_done", {63'd0, seen_done}, 64'd0);
    run_op("t5", 32'h00000000, 32'h7FFFFFFF, 64'h0);

    // 6: one-cycle start pulse while running is ignored
    @(negedge clk);
    multiplicand = 32'h00000003;
    multiplier   = 32'hFFFFFFFE;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    multiplicand = 32'h55555555;
    multiplier   = 32'h66666666;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    wait_done(cyc, busy_ok);
    check("t6_latency", 64'(cyc + 6), 64'd32);
    check("t6_busy_run", {63'd0, busy_ok}, 64'd1);
    check("t6_product", product, 64'hFFFFFFFFFFFFFFFA);
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_after", {62'd0, busy, done}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Sequential radix-2 Booth multiplier: signed 32x32 -> 64-bit product.
- One add/subtract per clock, done through a single instance of the team's 32-bit carryBypassAdder (ports a, b, cin, result, cout, overflow).
- Sits directly downstream of the adder, consuming its result/overflow every cycle. It is the first multiplier stage of the Adders-and-Multipliers library.
- Start/busy/done handshake toward the requester.

Parameters:
- WIDTH, 32, operand width. Must equal the adder instance width; only 32 is supported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe. Sampled only in IDLE or DONE.
- multiplicand  in  WIDTH  signed operand M. Captured on the accepting edge.
- multiplier  in  WIDTH  signed operand Q. Captured on the accepting edge.
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; product valid
- product  out  2*WIDTH  signed product. Holds until the next done.

Behaviour:
- Reset (async, any state, including mid-RUN):
  - state=IDLE; A, Q, q_m1, M and count cleared to 0.
  - busy=0, done=0, product=0.
  - Any in-flight operation is abandoned; no done is issued.
- States: IDLE, RUN, DONE.
- Accepting edge (state IDLE or DONE, start=1):
  - M<=multiplicand, Q<=multiplier, A<=0, q_m1<=0, count<=0.
  - state<=RUN.
- DONE with start=0 -> IDLE.
- RUN: start is ignored and operands are not re-sampled.
- Adder hookup (combinational, every cycle):
  - a=A.
  - {Q[0],q_m1}=01: b=M, cin=0.
  - {Q[0],q_m1}=10: b=~M, cin=1 (A-M).
  - 00 or 11: b=0, cin=0 (pass-through).
- RUN iteration on each edge:
  - S=adder.result.
  - s_msb = S[WIDTH-1] XOR adder.overflow. This is the true sign of the (WIDTH+1)-bit sum and is required for M=0x80000000.
  - Arithmetic right shift: {A,Q,q_m1} <= {s_msb, S, Q}.
  - count<=count+1.
  - adder.cout is unused.
- count==WIDTH-1 at an edge in RUN:
  - That edge performs the final iteration.
  - product <= {shifted A, shifted Q}.
  - done<=1, state<=DONE.
- Timing: with the accepting edge at k, busy=1 from k through k+WIDTH; done=1 for exactly one cycle, from edge k+WIDTH to k+WIDTH+1.
  - Latency = WIDTH clocks from acceptance to done.
- Back-to-back: start=1 during DONE is accepted.
  - Next RUN begins on the edge following done; throughput is one product per WIDTH+1 clocks.
  - product keeps its old value until the new done.
- done and busy are never both high.
- Product is exact for all signed inputs; no overflow or saturation is possible.
- The adder is a combinational path inside one cycle. clk period must cover adder delay plus the register setup time.

Test Plan:
1. M=0xFFFFFFFD (-3), Q=0x00000005 -> done exactly 32 clocks after the accepting edge; product=0xFFFFFFFFFFFFFFF1; busy high for the 32 cycles before done.
2. M=0x80000000, Q=0x80000000 -> product=0x4000000000000000. Exercises subtract overflow and the s_msb correction.
3. M=0x7FFFFFFF, Q=0x7FFFFFFF -> product=0x3FFFFFFF00000001. Then M=0x80000000, Q=0xFFFFFFFF -> product=0x0000000080000000.
4. Back-to-back: start held high. First M=0x00000007, Q=0x00000006 -> product=0x2A. Operands are changed while busy and must be ignored. Second op M=0xFFFFFFFF, Q=0xFFFFFFFF is accepted in the DONE cycle -> product=0x1, done exactly 33 clocks after the first done.
5. Reset mid-operation: accept M=0x12345678, Q=0x9ABCDEF0, assert rst at iteration 10 -> busy, done and product go to 0 immediately (asynchronously). No done is issued. A later start with M=0, Q=0x7FFFFFFF gives product=0.
6. start=1 for one cycle while busy (mid-RUN) -> no effect on the result or on done timing of the current op; state returns to IDLE after DONE.
